// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle for alu_arbiter: operands, operation select and valid/ready.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       funct3;
    logic [6:0]       funct7;

    modport master (
        output valid, a, b, funct3, funct7,
        input  ready
    );

    modport slave (
        input  valid, a, b, funct3, funct7,
        output ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// Operand stage feeds the ALU; result stage returns the answer two cycles after acceptance.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_arbiter_if.slave     i_req0,
    alu_arbiter_if.slave     i_req1,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [2:0]       o_alu_funct3,
    output logic [6:0]       o_alu_funct7,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic             o_rsp0_valid,
    output logic             o_rsp1_valid,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_busy
);

    logic             r_prio;
    logic             r_s1_valid;
    logic             r_s1_id;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_funct3;
    logic [6:0]       r_alu_funct7;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [WIDTH-1:0] r_rsp_result;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_xfer;

    // Ready is gated by reset so no request is taken while the pipeline is being cleared.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            w_gnt0 = i_req0.valid && (!i_req1.valid || !r_prio);
            w_gnt1 = i_req1.valid && (!i_req0.valid ||  r_prio);
        end
    end

    assign w_xfer       = w_gnt0 | w_gnt1;
    assign i_req0.ready = w_gnt0;
    assign i_req1.ready = w_gnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio       <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_id      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_funct3 <= '0;
            r_alu_funct7 <= '0;
        end else if (w_xfer) begin
            r_prio       <= w_gnt0;
            r_s1_valid   <= 1'b1;
            r_s1_id      <= w_gnt1;
            r_alu_a      <= w_gnt1 ? i_req1.a      : i_req0.a;
            r_alu_b      <= w_gnt1 ? i_req1.b      : i_req0.b;
            r_alu_funct3 <= w_gnt1 ? i_req1.funct3 : i_req0.funct3;
            r_alu_funct7 <= w_gnt1 ? i_req1.funct7 : i_req0.funct7;
        end else begin
            r_s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_result <= '0;
        end else if (r_s1_valid) begin
            r_rsp0_valid <= !r_s1_id;
            r_rsp1_valid <=  r_s1_id;
            r_rsp_result <= i_alu_result;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end
    end

    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_funct3 = r_alu_funct3;
    assign o_alu_funct7 = r_alu_funct7;
    assign o_rsp0_valid = r_rsp0_valid;
    assign o_rsp1_valid = r_rsp1_valid;
    assign o_rsp_result = r_rsp_result;
    assign o_busy       = r_s1_valid | r_rsp0_valid | r_rsp1_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with an in-bench ALU and a cycle-indexed scoreboard.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a, alu_b, alu_result, rsp_result;
    logic [2:0]  alu_f3;
    logic [6:0]  alu_f7;
    logic        rsp0_valid, rsp1_valid, busy;

    alu_arbiter_if #(.WIDTH(32)) req0_if ();
    alu_arbiter_if #(.WIDTH(32)) req1_if ();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (rst),
        .i_req0       (req0_if.slave),
        .i_req1       (req1_if.slave),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_funct3 (alu_f3),
        .o_alu_funct7 (alu_f7),
        .i_alu_result (alu_result),
        .o_rsp0_valid (rsp0_valid),
        .o_rsp1_valid (rsp1_valid),
        .o_rsp_result (rsp_result),
        .o_busy       (busy)
    );

    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b,
                                           logic [2:0] f3, logic [6:0] f7);
        case (f3)
            3'd0: return (f7 == 7'h20) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_f3, alu_f7);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          m_prio   = 0;
    logic [31:0] m_last   = 0;
    logic [31:0] m_a = 0, m_b = 0;
    logic [2:0]  m_f3 = 0;
    logic [6:0]  m_f7 = 0;
    int          sb_id  [int];
    logic [31:0] sb_res [int];
    logic        obs_r0, obs_r1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic set_req(int n, logic v, logic [31:0] a, logic [31:0] b,
                           logic [2:0] f3, logic [6:0] f7);
        if (n == 0) begin
            req0_if.valid = v; req0_if.a = a; req0_if.b = b;
            req0_if.funct3 = f3; req0_if.funct7 = f7;
        end else begin
            req1_if.valid = v; req1_if.a = a; req1_if.b = b;
            req1_if.funct3 = f3; req1_if.funct7 = f7;
        end
    endtask

    // One clock cycle: check settled outputs against the model, then advance the model past the edge.
    task automatic step();
        logic eg0, eg1, er0, er1, ebusy;
        #3;
        obs_r0 = req0_if.ready;
        obs_r1 = req1_if.ready;
        eg0 = !rst && req0_if.valid && (!req1_if.valid || m_prio == 0);
        eg1 = !rst && req1_if.valid && (!req0_if.valid || m_prio == 1);
        er0 = 1'b0;
        er1 = 1'b0;
        if (sb_id.exists(cyc)) begin
            er0 = (sb_id[cyc] == 0);
            er1 = (sb_id[cyc] == 1);
            m_last = sb_res[cyc];
        end
        ebusy = sb_id.exists(cyc) || sb_id.exists(cyc + 1);
        chk("ready0", 32'(obs_r0), 32'(eg0));
        chk("ready1", 32'(obs_r1), 32'(eg1));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(er0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(er1));
        chk("rsp_result", rsp_result, m_last);
        chk("busy", 32'(busy), 32'(ebusy));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_funct", {22'd0, alu_f7, alu_f3}, {22'd0, m_f7, m_f3});
        if (sb_id.exists(cyc)) begin
            sb_id.delete(cyc);
            sb_res.delete(cyc);
        end
        if (rst) begin
            if (sb_id.exists(cyc + 1)) begin sb_id.delete(cyc + 1); sb_res.delete(cyc + 1); end
            if (sb_id.exists(cyc + 2)) begin sb_id.delete(cyc + 2); sb_res.delete(cyc + 2); end
            m_prio = 0; m_last = 0;
            m_a = 0; m_b = 0; m_f3 = 0; m_f7 = 0;
        end else if (eg0 || eg1) begin
            if (eg1) begin
                m_a = req1_if.a; m_b = req1_if.b; m_f3 = req1_if.funct3; m_f7 = req1_if.funct7;
            end else begin
                m_a = req0_if.a; m_b = req0_if.b; m_f3 = req0_if.funct3; m_f7 = req0_if.funct7;
            end
            sb_id[cyc + 2]  = eg1 ? 1 : 0;
            sb_res[cyc + 2] = alu_fn(m_a, m_b, m_f3, m_f7);
            m_prio = eg0 ? 1 : 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, 0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step();
        step();

        // Both requesters valid from reset: grants alternate starting with requester 0.
        rst = 1'b0;
        set_req(0, 1'b1, 32'd10, 32'd3, 3'd0, 7'h20);
        set_req(1, 1'b1, 32'hF0, 32'hFF, 3'd4, 7'h00);
        step(); chk("alt_g0", 32'(obs_r0), 32'd1);
        step(); chk("alt_g1", 32'(obs_r1), 32'd1);
        chk("alt_rsp0a", 32'(rsp0_valid), 32'd1); chk("alt_res0a", rsp_result, 32'd7);
        step(); chk("alt_g2", 32'(obs_r0), 32'd1);
        chk("alt_rsp1a", 32'(rsp1_valid), 32'd1); chk("alt_res1a", rsp_result, 32'h0F);
        step(); chk("alt_g3", 32'(obs_r1), 32'd1);
        chk("alt_rsp0b", 32'(rsp0_valid), 32'd1); chk("alt_res0b", rsp_result, 32'd7);
        set_req(0, 1'b0, 0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0, 0);
        step(); chk("alt_rsp1b", 32'(rsp1_valid), 32'd1); chk("alt_res1b", rsp_result, 32'h0F);
        step(); chk("alt_idle", 32'(busy), 32'd0);

        rst = 1'b1; step(); rst = 1'b0;

        // Single ADD from requester 0.
        set_req(0, 1'b1, 32'd5, 32'd3, 3'd0, 7'h00);
        step(); chk("add_ready", 32'(obs_r0), 32'd1);
        set_req(0, 1'b0, 0, 0, 0, 0);
        step();
        chk("add_rsp0", 32'(rsp0_valid), 32'd1);
        chk("add_res", rsp_result, 32'd8);
        chk("add_rsp1", 32'(rsp1_valid), 32'd0);
        step();

        // Arithmetic and logical right shift from requester 1.
        set_req(1, 1'b1, 32'h8000_0000, 32'd4, 3'd5, 7'h20);
        step(); set_req(1, 1'b0, 0, 0, 0, 0); step();
        chk("sra_rsp1", 32'(rsp1_valid), 32'd1); chk("sra_res", rsp_result, 32'hF800_0000);
        set_req(1, 1'b1, 32'h8000_0000, 32'd4, 3'd5, 7'h00);
        step(); set_req(1, 1'b0, 0, 0, 0, 0); step();
        chk("srl_rsp1", 32'(rsp1_valid), 32'd1); chk("srl_res", rsp_result, 32'h0800_0000);
        step();

        // Back-to-back requester 0 operations.
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'd2, 7'h00); step();
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'd3, 7'h00); step();
        chk("b2b_busy0", 32'(busy), 32'd1);
        chk("b2b_res0", rsp_result, 32'd1);
        set_req(0, 1'b1, 32'd1, 32'd31, 3'd1, 7'h00); step();
        chk("b2b_res1", rsp_result, 32'd0); chk("b2b_v1", 32'(rsp0_valid), 32'd1);
        set_req(0, 1'b1, 32'hFF, 32'h0F, 3'd7, 7'h00); step();
        chk("b2b_res2", rsp_result, 32'h8000_0000); chk("b2b_v2", 32'(rsp0_valid), 32'd1);
        set_req(0, 1'b0, 0, 0, 0, 0); step();
        chk("b2b_res3", rsp_result, 32'h0F); chk("b2b_busy3", 32'(busy), 32'd1);
        step();

        // Reset right after an acceptance drops the in-flight operation and the pointer.
        set_req(0, 1'b1, 32'd100, 32'd1, 3'd0, 7'h00); step();
        set_req(0, 1'b0, 0, 0, 0, 0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_rsp0", 32'(rsp0_valid), 32'd0);
        chk("rst_res", rsp_result, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        set_req(0, 1'b1, 32'd2, 32'd2, 3'd0, 7'h00);
        set_req(1, 1'b1, 32'd4, 32'd4, 3'd0, 7'h00);
        step(); chk("rst_prio", 32'(obs_r0), 32'd1);
        set_req(0, 1'b0, 0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0, 0);
        step(); step();

        // Requester 1 drops its request while requester 0 holds priority.
        set_req(1, 1'b1, 32'd9, 32'd9, 3'd6, 7'h00); step();
        set_req(1, 1'b0, 0, 0, 0, 0); step(); step(); step();
        set_req(0, 1'b1, 32'd6, 32'd1, 3'd0, 7'h20);
        set_req(1, 1'b1, 32'd7, 32'd7, 3'd4, 7'h00);
        step(); chk("drop_r1", 32'(obs_r1), 32'd0);
        set_req(0, 1'b0, 0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0, 0);
        step();
        chk("drop_rsp0", 32'(rsp0_valid), 32'd1); chk("drop_res", rsp_result, 32'd5);
        step(); chk("drop_rsp1", 32'(rsp1_valid), 32'd0);
        step();

        // Randomized traffic with legal hold/drop behaviour and occasional reset.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            if (req0_if.valid && !obs_r0) begin
                if ($urandom_range(0, 99) < 15) req0_if.valid = 1'b0;
            end else begin
                set_req(0, 1'($urandom_range(0, 1)), $urandom, $urandom,
                        3'($urandom_range(0, 7)), $urandom_range(0, 1) ? 7'h20 : 7'h00);
            end
            if (req1_if.valid && !obs_r1) begin
                if ($urandom_range(0, 99) < 15) req1_if.valid = 1'b0;
            end else begin
                set_req(1, 1'($urandom_range(0, 1)), $urandom, $urandom,
                        3'($urandom_range(0, 7)), $urandom_range(0, 1) ? 7'h20 : 7'h00);
            end
            step();
        end
        rst = 1'b0;
        set_req(0, 1'b0, 0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0, 0);
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single combinational integer ALU between two requesters, such as the execute stage and an address-generation or branch-compare unit. Each requester presents operands and an operation code through a valid/ready handshake. A round-robin arbiter grants one request per cycle and registers the operands into an operand stage that drives the ALU. The ALU result is captured and returned to the granted requester two cycles after acceptance, with a sustained throughput of one operation per cycle.

## Interface
- WIDTH, 32, operand and result width (ALU shift amount is taken from B[4:0] by the ALU)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_funct3  in  3  requester 0 operation select
- req0_funct7  in  7  requester 0 modifier (0x20 selects SUB/SRA)
- req1_valid, req1_ready, req1_a, req1_b, req1_funct3, req1_funct7: same as requester 0, for requester 1
- alu_a, alu_b  out  WIDTH  registered operands to the ALU
- alu_funct3  out  3  registered funct3 to the ALU
- alu_funct7  out  7  registered funct7 to the ALU
- alu_result  in  WIDTH  combinational ALU output
- rsp0_valid  out  1  one-cycle pulse: result for requester 0
- rsp1_valid  out  1  one-cycle pulse: result for requester 1
- rsp_result  out  WIDTH  registered result, valid when either rsp valid is high
- busy  out  1  high while any operation is in the operand or result stage

## Operation
**Arbitration**
- Combinational, every cycle.
- Only one requester valid: that requester is granted.
- Both valid: the requester named by priority pointer `prio` is granted.
- `reqN_ready` equals grant N. At most one ready is high in any cycle.
- Ready never asserts when the corresponding valid is low.

**Priority pointer**
- After each grant, `prio` moves to the non-granted requester.
- If no grant occurs, `prio` holds its value.
- Reset value is 0.

**Handshake**
- Transfer occurs when valid and ready are both high at a rising edge.
- The requester holds valid and a stable payload until ready is seen.
- Dropping valid before ready is legal. The request is discarded and no response is produced.

**Operand stage (S1)**
- On transfer: `alu_a`, `alu_b`, `alu_funct3` and `alu_funct7` load the granted payload.
- The internal `s1_valid` is set and `s1_id` records the granted requester.
- With no transfer, `s1_valid` clears and the alu_* registers hold their last value. They are don't-care to consumers, but must not glitch to X.

**Result stage (S2)**
- At each edge where `s1_valid`=1, `rsp_result` loads `alu_result`.
- The rsp valid for `s1_id` is set. The other rsp valid is cleared.
- At edges where `s1_valid`=0, both rsp valids clear and `rsp_result` holds.

**Other rules**
- Responses have no back-pressure. The requester must consume a response in the cycle it is presented.
- `busy` = `s1_valid` | `rsp0_valid` | `rsp1_valid`.
- No arithmetic is performed in this block. Widths pass through unmodified.

## Timing
**Reset values (at the first edge with reset=1):**
- `alu_a` = `alu_b` = 0, `alu_funct3` = 0, `alu_funct7` = 0
- `rsp_result` = 0, `rsp0_valid` = `rsp1_valid` = 0
- `s1_valid` = 0, `prio` = 0, `busy` = 0
- `req0_ready` and `req1_ready` are forced to 0 while reset=1.

**Latency and throughput**
- A request accepted at edge E appears on alu_* in the cycle after E.
- Its response is visible (rsp valid = 1, `rsp_result` valid) in the cycle after edge E+1, i.e. 2 cycles after acceptance.
- Throughput is one accepted request per cycle, sustained.
- With both requesters continuously valid, grants alternate 0,1,0,1,… starting from the `prio` value.

**Boundary conditions**
- Simultaneous request and response for the same requester: legal. Req ready and rsp valid may both be high in the same cycle.
- Reset mid-operation: in-flight S1/S2 contents are dropped and no rsp pulse is produced after reset.
- A requester still holding valid after reset is re-arbitrated normally in the first cycle with reset=0.

## Test plan
- Reset, then req0: a=5, b=3, funct3=0, funct7=0, held valid for 1 cycle. Expect: req0_ready=1 in that cycle; rsp0_valid=1 with rsp_result=8 exactly 2 cycles later; rsp1_valid stays 0.
- Both valid every cycle from reset. req0 is SUB: 10−3, funct7=0x20. req1 is XOR: 0xF0^0xFF. Expect: grants 0,1,0,1. Responses alternate rsp0 (7) and rsp1 (0x0F), one per cycle.
- req1 only: a=0x80000000, b=4, funct3=5, funct7=0x20. Expect: rsp1_valid with rsp_result=0xF8000000. Repeat with funct7=0: expect 0x08000000.
- Back-to-back req0 for 4 cycles: SLT(−1,1), SLTU(0xFFFFFFFF,1), SLL(1,31), AND(0xFF,0x0F). Expect 4 consecutive rsp0 pulses with results 1, 0, 0x80000000, 0x0F; busy high throughout.
- req0 accepted, then reset asserted for 1 cycle at the next edge. Expect: no rsp0/rsp1 pulse, all outputs at reset values, `prio` = 0.
- req1 valid and then dropped before ready while req0 wins. Expect: only the req0 response appears; no rsp1_valid pulse.
